sar_sequencer: RTL and testbench

- Multi-channel conversion scheduler for the generic SAR ADC, in the f100m_clk domain, placed after the toggle resynchronisers.
- Drives the analogue input mux select and issues single-cycle start-of-conversion pulses. Consumes the resynced eoc/err/warn pulses and the 10-bit code.
- Scans a masked channel list once or continuously, averages 2^k conversions per channel and publishes one result per channel.
- Recovers from a stalled converter with a timeout.

---
 rtl/sar_sequencer.sv | 222 ++++++++++++++++++++++
 tb/tb_sar_sequencer.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sar_sequencer.sv
// Multi-channel SAR conversion scheduler: masked channel scan (single or continuous),
// 2^k averaging per channel, one result strobe per channel and stall recovery by timeout.
module sar_sequencer #(
  parameter int NCH         = 4,
  parameter int CH_W        = 2,
  parameter int CODE_W      = 10,
  parameter int SETTLE_CYC  = 8,
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic              f100m_clk,
  input  logic              rstb,
  input  logic              cfg_en,
  input  logic              cfg_cont,
  input  logic [NCH-1:0]    cfg_ch_mask,
  input  logic [1:0]        cfg_avg_log2,
  input  logic              start,
  output logic              soc,
  input  logic              eoc,
  input  logic              err,
  input  logic              warn,
  input  logic [CODE_W-1:0] sar_code,
  output logic [CH_W-1:0]   mux_sel,
  output logic              busy,
  output logic              res_valid,
  output logic [CH_W-1:0]   res_ch,
  output logic [CODE_W-1:0] res_code,
  output logic              res_warn,
  output logic              conv_err,
  output logic              timeout_err
);
  localparam int SET_W = $clog2(SETTLE_CYC + 1);
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  localparam int ACC_W = CODE_W + 3;
  localparam logic [SET_W-1:0] SET_RELOAD = SET_W'(SETTLE_CYC - 1);
  localparam logic [TMO_W-1:0] TMO_LOAD   = TMO_W'(TIMEOUT_CYC);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SETTLE = 3'd1;
  localparam logic [2:0] S_SOC    = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_NEXT   = 3'd4;

  logic [2:0]        r_state;
  logic [2:0]        w_state_nxt;
  logic              r_cont;
  logic [NCH-1:0]    r_mask;
  logic [1:0]        r_avg;
  logic [CH_W-1:0]   r_ch;
  logic [SET_W-1:0]  r_set_cnt;
  logic [TMO_W-1:0]  r_tmo_cnt;
  logic [ACC_W-1:0]  r_acc;
  logic [3:0]        r_cnt;
  logic              r_warn;
  logic              r_stop;
  logic              r_soc;
  logic              r_busy;
  logic              r_res_valid;
  logic [CH_W-1:0]   r_res_ch;
  logic [CODE_W-1:0] r_res_code;
  logic              r_res_warn;
  logic              r_conv_err;
  logic              r_tmo_err;

  logic              w_start_ok;
  logic              w_stop;
  logic [ACC_W-1:0]  w_acc_sum;
  logic [3:0]        w_cnt_inc;
  logic              w_avg_done;
  logic [CH_W-1:0]   w_lo_cfg;
  logic [CH_W-1:0]   w_lo_sh;
  logic [CH_W:0]     w_hi;

  function automatic logic [CH_W-1:0] lowest_bit(input logic [NCH-1:0] mask);
    lowest_bit = {CH_W{1'b0}};
    for (int i = NCH - 1; i >= 0; i--) begin
      if (mask[i]) lowest_bit = CH_W'(i);
    end
  endfunction

  // MSB flags that a set mask bit above ch exists; low bits give the nearest one
  function automatic logic [CH_W:0] next_bit(input logic [NCH-1:0] mask, input logic [CH_W-1:0] ch);
    next_bit = {(CH_W + 1){1'b0}};
    for (int i = NCH - 1; i >= 0; i--) begin
      if (mask[i] && (CH_W'(i) > ch)) next_bit = {1'b1, CH_W'(i)};
    end
  endfunction

  assign w_start_ok = start && cfg_en && (|cfg_ch_mask);
  assign w_stop     = r_stop || !cfg_en;
  assign w_acc_sum  = r_acc + {3'b000, sar_code};
  assign w_cnt_inc  = r_cnt + 4'd1;
  assign w_avg_done = (w_cnt_inc == (4'd1 << r_avg));
  assign w_lo_cfg   = lowest_bit(cfg_ch_mask);
  assign w_lo_sh    = lowest_bit(r_mask);
  assign w_hi       = next_bit(r_mask, r_ch);

  // Next-state decision; err outranks a simultaneous eoc
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_start_ok) w_state_nxt = S_SETTLE;
        else            w_state_nxt = S_IDLE;
      end
      S_SETTLE: begin
        if (!cfg_en)                         w_state_nxt = S_IDLE;
        else if (r_set_cnt == {SET_W{1'b0}}) w_state_nxt = S_SOC;
        else                                 w_state_nxt = S_SETTLE;
      end
      S_SOC: w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (w_stop && (err || eoc))          w_state_nxt = S_IDLE;
        else if (err || (eoc && w_avg_done)) w_state_nxt = S_NEXT;
        else if (eoc)                        w_state_nxt = S_SOC;
        else if (r_tmo_cnt <= TMO_W'(1))     w_state_nxt = S_IDLE;
        else                                 w_state_nxt = S_WAIT;
      end
      S_NEXT: begin
        if (w_hi[CH_W] || (r_cont && cfg_en)) w_state_nxt = S_SETTLE;
        else                                  w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State, registered outputs, shadow config and averaging datapath
  always_ff @(posedge f100m_clk or negedge rstb) begin
    if (!rstb) begin
      r_state     <= S_IDLE;
      r_cont      <= 1'b0;
      r_mask      <= {NCH{1'b0}};
      r_avg       <= 2'd0;
      r_ch        <= {CH_W{1'b0}};
      r_set_cnt   <= {SET_W{1'b0}};
      r_tmo_cnt   <= {TMO_W{1'b0}};
      r_acc       <= {ACC_W{1'b0}};
      r_cnt       <= 4'd0;
      r_warn      <= 1'b0;
      r_stop      <= 1'b0;
      r_soc       <= 1'b0;
      r_busy      <= 1'b0;
      r_res_valid <= 1'b0;
      r_res_ch    <= {CH_W{1'b0}};
      r_res_code  <= {CODE_W{1'b0}};
      r_res_warn  <= 1'b0;
      r_conv_err  <= 1'b0;
      r_tmo_err   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_busy      <= (w_state_nxt != S_IDLE);
      r_soc       <= (w_state_nxt == S_SOC);
      r_res_valid <= 1'b0;
      r_conv_err  <= 1'b0;
      r_tmo_err   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_start_ok) begin
            r_cont    <= cfg_cont;
            r_mask    <= cfg_ch_mask;
            r_avg     <= cfg_avg_log2;
            r_ch      <= w_lo_cfg;
            r_set_cnt <= SET_RELOAD;
            r_acc     <= {ACC_W{1'b0}};
            r_cnt     <= 4'd0;
            r_warn    <= 1'b0;
            r_stop    <= 1'b0;
          end
        end
        S_SETTLE: begin
          if (r_set_cnt != {SET_W{1'b0}}) r_set_cnt <= r_set_cnt - SET_W'(1);
        end
        S_SOC: r_tmo_cnt <= TMO_LOAD;
        S_WAIT: begin
          r_tmo_cnt <= r_tmo_cnt - TMO_W'(1);
          if (!cfg_en) r_stop <= 1'b1;
          if (err) begin
            r_conv_err <= 1'b1;
            r_acc      <= {ACC_W{1'b0}};
            r_cnt      <= 4'd0;
            r_warn     <= 1'b0;
          end else if (eoc && w_avg_done) begin
            r_res_valid <= 1'b1;
            r_res_ch    <= r_ch;
            r_res_code  <= CODE_W'(w_acc_sum >> r_avg);
            r_res_warn  <= r_warn || warn;
            r_acc       <= {ACC_W{1'b0}};
            r_cnt       <= 4'd0;
            r_warn      <= 1'b0;
          end else if (eoc) begin
            r_acc <= w_acc_sum;
            r_cnt <= w_cnt_inc;
            if (warn) r_warn <= 1'b1;
          end else if (r_tmo_cnt <= TMO_W'(1)) begin
            r_tmo_err <= 1'b1;
            r_acc     <= {ACC_W{1'b0}};
            r_cnt     <= 4'd0;
            r_warn    <= 1'b0;
          end else if (warn) begin
            r_warn <= 1'b1;
          end
        end
        S_NEXT: begin
          if (w_state_nxt == S_SETTLE) begin
            r_ch      <= w_hi[CH_W] ? w_hi[CH_W-1:0] : w_lo_sh;
            r_set_cnt <= SET_RELOAD;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign soc         = r_soc;
  assign busy        = r_busy;
  assign mux_sel     = r_ch;
  assign res_valid   = r_res_valid;
  assign res_ch      = r_res_ch;
  assign res_code    = r_res_code;
  assign res_warn    = r_res_warn;
  assign conv_err    = r_conv_err;
  assign timeout_err = r_tmo_err;
endmodule

// File: tb/tb_sar_sequencer.sv
// Bench for sar_sequencer: a converter model answers each soc, a monitor logs events,
// and directed plus randomized scans are checked against per-channel averages.
module tb_sar_sequencer;
  logic       f100m_clk = 1'b0;
  logic       rstb = 1'b1;
  logic       cfg_en = 1'b0, cfg_cont = 1'b0, start = 1'b0;
  logic [3:0] cfg_ch_mask = 4'd0;
  logic [1:0] cfg_avg_log2 = 2'd0;
  logic       eoc, err, warn;
  logic [9:0] sar_code;
  logic       soc, busy, res_valid, res_warn, conv_err, timeout_err;
  logic [1:0] mux_sel, res_ch;
  logic [9:0] res_code;

  always #5 f100m_clk = ~f100m_clk;
  int cyc = 0;
  always @(posedge f100m_clk) cyc <= cyc + 1;

  sar_sequencer dut (
    .f100m_clk(f100m_clk), .rstb(rstb), .cfg_en(cfg_en), .cfg_cont(cfg_cont),
    .cfg_ch_mask(cfg_ch_mask), .cfg_avg_log2(cfg_avg_log2), .start(start), .soc(soc),
    .eoc(eoc), .err(err), .warn(warn), .sar_code(sar_code), .mux_sel(mux_sel), .busy(busy),
    .res_valid(res_valid), .res_ch(res_ch), .res_code(res_code), .res_warn(res_warn),
    .conv_err(conv_err), .timeout_err(timeout_err)
  );

  int total = 0, bad = 0;
  int code_tab [4][8];
  int conv_idx [4];
  int conv_no = 0, resp_lat = 40, err_conv = -1, warn_conv = -1;
  bit resp_on = 1'b1, stray_req = 1'b0;
  int pend_cnt = 0, pend_ch = 0, pend_k = 0, pend_no = 0;

  int rq_ch[$], rq_code[$], rq_warn[$], rq_cyc[$], gaps[$], soc_ch[$];
  int exp_ch[$], exp_code[$], exp_warn[$];
  int soc_cnt = 0, soc_last = 0, cerr_cnt = 0, tmo_cnt = 0, tmo_cyc = 0;
  int busy_fall_cyc = 0, mark_cyc = 0;

  // Converter model: eoc resp_lat cycles after each soc, optional warn/err injection
  initial begin
    eoc = 1'b0; err = 1'b0; warn = 1'b0; sar_code = 10'd0;
    forever begin
      @(negedge f100m_clk);
      eoc = 1'b0; err = 1'b0; warn = 1'b0;
      if (stray_req) begin eoc = 1'b1; sar_code = 10'd777; stray_req = 1'b0; end
      if (pend_cnt > 0) begin
        pend_cnt--;
        if (pend_no == warn_conv && pend_cnt == 5) warn = 1'b1;
        if (pend_cnt == 0) begin
          eoc = 1'b1;
          sar_code = 10'(code_tab[pend_ch][pend_k % 8]);
          if (pend_no == err_conv) err = 1'b1;
        end
      end
      if (soc === 1'b1) begin
        pend_ch = int'(mux_sel);
        pend_k = conv_idx[pend_ch];
        conv_idx[pend_ch]++;
        pend_no = conv_no;
        conv_no++;
        pend_cnt = resp_on ? resp_lat : 0;
      end
    end
  end

  // Event monitor
  initial begin
    bit pbusy;
    logic [1:0] pmux;
    pbusy = 1'b0; pmux = 2'd0;
    forever begin
      @(negedge f100m_clk);
      if ((busy && !pbusy) || (mux_sel != pmux)) mark_cyc = cyc;
      if (!busy && pbusy) busy_fall_cyc = cyc;
      if (soc === 1'b1) begin
        soc_cnt++; soc_last = cyc;
        gaps.push_back(cyc - mark_cyc); soc_ch.push_back(int'(mux_sel));
      end
      if (res_valid === 1'b1) begin
        rq_ch.push_back(int'(res_ch)); rq_code.push_back(int'(res_code));
        rq_warn.push_back(int'(res_warn)); rq_cyc.push_back(cyc);
      end
      if (conv_err === 1'b1) cerr_cnt++;
      if (timeout_err === 1'b1) begin tmo_cnt++; tmo_cyc = cyc; end
      pbusy = busy; pmux = mux_sel;
    end
  end

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    rq_ch.delete(); rq_code.delete(); rq_warn.delete(); rq_cyc.delete();
    gaps.delete(); soc_ch.delete();
    exp_ch.delete(); exp_code.delete(); exp_warn.delete();
    soc_cnt = 0; cerr_cnt = 0; tmo_cnt = 0; conv_no = 0;
    err_conv = -1; warn_conv = -1;
    for (int c = 0; c < 4; c++) conv_idx[c] = 0;
  endtask

  task automatic do_start();
    @(negedge f100m_clk); start = 1'b1;
    @(negedge f100m_clk); start = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n;
    n = 0;
    while (busy === 1'b1 && n < budget) begin @(negedge f100m_clk); n++; end
    check(tag, int'(busy), 0);
  endtask

  task automatic check_results(input string tag);
    check({tag, "_count"}, rq_ch.size(), exp_ch.size());
    for (int i = 0; i < exp_ch.size() && i < rq_ch.size(); i++) begin
      check($sformatf("%s_ch%0d", tag, i), rq_ch[i], exp_ch[i]);
      check($sformatf("%s_code%0d", tag, i), rq_code[i], exp_code[i]);
      check($sformatf("%s_warn%0d", tag, i), rq_warn[i], exp_warn[i]);
    end
  endtask

  // Reference: mean of the 2^avg codes the converter returns for a channel, truncated
  function automatic int avg_of(input int ch, input int avg);
    int s;
    s = 0;
    for (int k = 0; k < (1 << avg); k++) s += code_tab[ch][k];
    return s >> avg;
  endfunction

  initial begin
    int n, nsoc, m, a, pop;
    #1 rstb = 1'b0;
    #11;
    check("rst_busy", int'(busy), 0);
    check("rst_soc", int'(soc), 0);
    check("rst_mux", int'(mux_sel), 0);
    check("rst_res", int'({res_valid, res_ch, res_code, res_warn}), 0);
    check("rst_errs", int'({conv_err, timeout_err}), 0);
    @(negedge f100m_clk); rstb = 1'b1; cfg_en = 1'b1;
    repeat (3) @(negedge f100m_clk);

    // Single scan, mask 0101
    clear_log();
    for (int c = 0; c < 4; c++) for (int k = 0; k < 8; k++) code_tab[c][k] = c * 100 + 5;
    cfg_ch_mask = 4'b0101; cfg_avg_log2 = 2'd0; cfg_cont = 1'b0; resp_lat = 40;
    do_start();
    check("s1_busy_rise", int'(busy), 1);
    wait_idle("s1_idle", 1000);
    check("s1_soc_cnt", soc_cnt, 2);
    check("s1_gap0", (gaps.size() > 0) ? gaps[0] : -1, 8);
    check("s1_gap1", (gaps.size() > 1) ? gaps[1] : -1, 8);
    check("s1_soc_ch1", (soc_ch.size() > 1) ? soc_ch[1] : -1, 2);
    exp_ch = '{0, 2}; exp_code = '{5, 205}; exp_warn = '{0, 0};
    check_results("s1");
    check("s1_busy_fall", busy_fall_cyc, (rq_cyc.size() > 1) ? rq_cyc[1] + 1 : -1);

    // Averaging, mask 0010, 4 conversions
    clear_log();
    code_tab[1][0] = 100; code_tab[1][1] = 101; code_tab[1][2] = 102; code_tab[1][3] = 104;
    cfg_ch_mask = 4'b0010; cfg_avg_log2 = 2'd2; resp_lat = 12;
    do_start();
    wait_idle("s2_idle", 1000);
    check("s2_soc_cnt", soc_cnt, 4);
    check("s2_gap0", (gaps.size() > 0) ? gaps[0] : -1, 8);
    exp_ch = '{1}; exp_code = '{101}; exp_warn = '{0};
    check_results("s2");
    clear_log();
    for (int k = 0; k < 8; k++) code_tab[1][k] = 1023;
    do_start();
    wait_idle("s2b_idle", 1000);
    exp_ch = '{1}; exp_code = '{1023}; exp_warn = '{0};
    check_results("s2b");

    // Continuous 0,3,0,3 then disable while waiting on ch3
    clear_log();
    for (int c = 0; c < 4; c++) for (int k = 0; k < 8; k++) code_tab[c][k] = c * 100 + 5;
    cfg_ch_mask = 4'b1001; cfg_avg_log2 = 2'd0; cfg_cont = 1'b1; resp_lat = 20;
    do_start();
    n = 0;
    while (rq_ch.size() < 3 && n < 2000) begin @(negedge f100m_clk); n++; end
    n = 0;
    while (!(soc === 1'b1 && mux_sel == 2'd3) && n < 200) begin @(negedge f100m_clk); n++; end
    check("s3_reached_ch3_soc", int'(soc === 1'b1 && mux_sel == 2'd3), 1);
    repeat (4) @(negedge f100m_clk);
    cfg_en = 1'b0;
    wait_idle("s3_idle", 200);
    nsoc = soc_cnt;
    repeat (100) @(negedge f100m_clk);
    check("s3_no_more_soc", soc_cnt, nsoc);
    exp_ch = '{0, 3, 0, 3}; exp_code = '{5, 305, 5, 305}; exp_warn = '{0, 0, 0, 0};
    check_results("s3");
    cfg_en = 1'b1; cfg_cont = 1'b0;

    // Timeout: converter silent
    clear_log();
    resp_on = 1'b0; cfg_ch_mask = 4'b0001;
    do_start();
    wait_idle("s4_idle", 1200);
    check("s4_tmo_cnt", tmo_cnt, 1);
    check("s4_tmo_delay", tmo_cyc - soc_last, 1024);
    check("s4_no_result", rq_ch.size(), 0);
    clear_log();
    resp_on = 1'b1;
    do_start();
    wait_idle("s4b_idle", 500);
    exp_ch = '{0}; exp_code = '{5}; exp_warn = '{0};
    check_results("s4b");

    // Warn on first conversion, err+eoc on second; ch1 result clean
    clear_log();
    code_tab[1][0] = 300; code_tab[1][1] = 303;
    cfg_ch_mask = 4'b0011; cfg_avg_log2 = 2'd1; resp_lat = 20;
    warn_conv = 0; err_conv = 1;
    do_start();
    wait_idle("s5_idle", 1000);
    check("s5_conv_err", cerr_cnt, 1);
    check("s5_soc_cnt", soc_cnt, 4);
    exp_ch = '{1}; exp_code = '{301}; exp_warn = '{0};
    check_results("s5");
    clear_log();
    cfg_ch_mask = 4'b0010; warn_conv = 0;
    do_start();
    wait_idle("s5b_idle", 1000);
    exp_ch = '{1}; exp_code = '{301}; exp_warn = '{1};
    check_results("s5b");

    // Corner inputs
    clear_log();
    cfg_ch_mask = 4'b0000;
    do_start();
    repeat (4) @(negedge f100m_clk);
    check("c_mask0_busy", int'(busy), 0);
    cfg_ch_mask = 4'b0001; cfg_en = 1'b0;
    do_start();
    repeat (4) @(negedge f100m_clk);
    check("c_en0_busy", int'(busy), 0);
    cfg_en = 1'b1;
    stray_req = 1'b1;
    repeat (6) @(negedge f100m_clk);
    check("c_no_soc", soc_cnt, 0);
    check("c_stray_no_res", rq_ch.size(), 0);
    check("c_stray_busy", int'(busy), 0);
    cfg_ch_mask = 4'b0100;
    do_start();
    repeat (2) @(negedge f100m_clk);
    check("c_settle_mux", int'(mux_sel), 2);
    #2 rstb = 1'b0;
    #1;
    check("c_rst_busy", int'(busy), 0);
    check("c_rst_mux", int'(mux_sel), 0);
    check("c_rst_soc", int'(soc), 0);
    @(negedge f100m_clk); rstb = 1'b1;
    repeat (60) @(negedge f100m_clk);
    check("c_post_rst_soc", soc_cnt, 0);

    // Randomized single scans; config changed after start must be ignored
    for (int it = 0; it < 8; it++) begin
      clear_log();
      m = $urandom_range(1, 15); a = $urandom_range(0, 3);
      resp_lat = $urandom_range(6, 30);
      for (int c = 0; c < 4; c++) for (int k = 0; k < 8; k++) code_tab[c][k] = $urandom_range(0, 1023);
      cfg_ch_mask = 4'(m); cfg_avg_log2 = 2'(a);
      pop = 0;
      for (int c = 0; c < 4; c++) begin
        if (m[c]) begin
          exp_ch.push_back(c); exp_code.push_back(avg_of(c, a)); exp_warn.push_back(0);
          pop++;
        end
      end
      do_start();
      cfg_ch_mask = 4'($urandom_range(0, 15)); cfg_avg_log2 = 2'($urandom_range(0, 3));
      cfg_cont = 1'($urandom_range(0, 1));
      wait_idle($sformatf("r%0d_idle", it), 6000);
      check($sformatf("r%0d_soc_cnt", it), soc_cnt, pop << a);
      check_results($sformatf("r%0d", it));
      cfg_cont = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
